// File: rtl/istra_iter_ctrl.sv
// Iteration sequencer for one stochastic ISTA tile: clears the tile, runs one
// counted bitstream window per iteration and stops on convergence or iteration limit.
//
// state | meaning
// IDLE  | waiting for start; result, iter_count and converged hold
// CLEAR | istra_init high for CLR_CYC cycles, acc/Rc/wc cleared
// RUN   | warm-up then counted window, Rc stepping every cycle
// LATCH | publish acc as result, decide converge/limit/next iteration
// DONE  | one-cycle completion pulse
module istra_iter_ctrl #(
    parameter int STREAM_LEN = 256,
    parameter int WARMUP     = 8,
    parameter int CLR_CYC    = 2,
    parameter int MAX_ITER   = 32,
    parameter int TOL        = 2,
    parameter int ACC_W      = $clog2(STREAM_LEN) + 2,
    parameter int IT_W       = $clog2(MAX_ITER + 1)
) (
    input  logic                    CLK,
    input  logic                    INIT_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    x_out,
    input  logic                    SIGN_x_out,
    output logic                    istra_init,
    output logic [1:0]              Rc,
    output logic                    busy,
    output logic                    result_valid,
    output logic signed [ACC_W-1:0] result,
    output logic [IT_W-1:0]         iter_count,
    output logic                    done,
    output logic                    converged
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int WC_W = $clog2(WARMUP + STREAM_LEN);
    localparam int CL_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(WARMUP + STREAM_LEN - 1);
    localparam logic [CL_W-1:0] CLR_LOAD = CL_W'(CLR_CYC - 1);
    localparam logic signed [ACC_W:0] TOL_S = (ACC_W + 1)'(TOL);

    logic [2:0]              state;
    logic [WC_W-1:0]         wc;
    logic [CL_W-1:0]         clr_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W:0]   delta;
    logic                    within_tol;
    logic                    counting;
    logic [IT_W:0]           iter_next;

    generate
        if (WARMUP == 0) begin : g_no_warm
            assign counting = 1'b1;
        end else begin : g_warm
            assign counting = (wc >= WC_W'(WARMUP));
        end
    endgenerate

    // The old result is the previous estimate, so no separate copy is needed for delta.
    always_comb begin
        step = '0;
        if (x_out) step = SIGN_x_out ? '1 : ACC_W'(1);
        delta      = {acc[ACC_W-1], acc} - {result[ACC_W-1], result};
        within_tol = (delta <= TOL_S) && (delta >= -TOL_S);
        iter_next  = {1'b0, iter_count} + (IT_W + 1)'(1);
    end

    always_ff @(posedge CLK) begin
        if (!INIT_n) begin
            state        <= S_IDLE;
            wc           <= '0;
            clr_cnt      <= '0;
            acc          <= '0;
            istra_init   <= 1'b0;
            Rc           <= 2'd0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            iter_count   <= '0;
            done         <= 1'b0;
            converged    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_CLEAR;
                        busy       <= 1'b1;
                        istra_init <= 1'b1;
                        clr_cnt    <= CLR_LOAD;
                        acc        <= '0;
                        wc         <= '0;
                        Rc         <= 2'd0;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        result     <= '0;
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        istra_init <= 1'b0;
                    end else begin
                        acc <= '0;
                        wc  <= '0;
                        Rc  <= 2'd0;
                        if (clr_cnt == '0) begin
                            state      <= S_RUN;
                            istra_init <= 1'b0;
                        end else begin
                            clr_cnt <= clr_cnt - CL_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        acc   <= '0;
                    end else begin
                        if (counting) acc <= acc + step;
                        if (wc == WC_LAST) begin
                            state        <= S_LATCH;
                            result_valid <= 1'b1;
                        end else begin
                            wc <= wc + WC_W'(1);
                            Rc <= Rc + 2'd1;
                        end
                    end
                end
                S_LATCH: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        acc   <= '0;
                    end else begin
                        result     <= acc;
                        iter_count <= iter_next[IT_W-1:0];
                        if ((iter_next >= (IT_W + 1)'(2)) && within_tol) begin
                            converged <= 1'b1;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else if (iter_next == (IT_W + 1)'(MAX_ITER)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state      <= S_CLEAR;
                            istra_init <= 1'b1;
                            clr_cnt    <= CLR_LOAD;
                            acc        <= '0;
                            wc         <= '0;
                            Rc         <= 2'd0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    istra_init <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_istra_iter_ctrl.sv
// Self-checking bench for istra_iter_ctrl: window scoreboard plus scenario tasks,
// with a second small instance for the short-window case.
module tb_istra_iter_ctrl;

    localparam int S      = 256;
    localparam int W      = 8;
    localparam int CLR    = 2;
    localparam int MAXI   = 32;
    localparam int TOL    = 2;
    localparam int ACC_W  = $clog2(S) + 2;
    localparam int IT_W   = $clog2(MAXI + 1);
    localparam int RUNL   = W + S;
    localparam int PERIOD = CLR + W + S + 1;
    localparam int SP     = 2 + 0 + 4 + 1;

    logic clk = 1'b0;
    logic init_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, x_out = 1'b0, sign_x = 1'b0;
    logic istra_init, busy, result_valid, done, converged;
    logic [1:0] Rc;
    logic signed [ACC_W-1:0] result;
    logic [IT_W-1:0] iter_count;

    logic s_start = 1'b0, s_abort = 1'b0, s_x = 1'b0, s_sign = 1'b0;
    logic s_init, s_busy, s_rv, s_done, s_conv;
    logic [1:0] s_rc;
    logic signed [3:0] s_result;
    logic [1:0] s_iter;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    logic rv_d = 1'b0;

    always #5 clk = ~clk;

    istra_iter_ctrl u_dut (
        .CLK(clk), .INIT_n(init_n), .start(start), .abort(abort),
        .x_out(x_out), .SIGN_x_out(sign_x), .istra_init(istra_init), .Rc(Rc),
        .busy(busy), .result_valid(result_valid), .result(result),
        .iter_count(iter_count), .done(done), .converged(converged)
    );

    istra_iter_ctrl #(.STREAM_LEN(4), .WARMUP(0), .MAX_ITER(3)) u_small (
        .CLK(clk), .INIT_n(init_n), .start(s_start), .abort(s_abort),
        .x_out(s_x), .SIGN_x_out(s_sign), .istra_init(s_init), .Rc(s_rc),
        .busy(s_busy), .result_valid(s_rv), .result(s_result),
        .iter_count(s_iter), .done(s_done), .converged(s_conv)
    );

    // Scoreboard: result must carry the queued window sum the cycle after result_valid.
    always @(negedge clk) begin
        if (rv_d === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_result: unexpected update, result=%0d", result);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (result !== ACC_W'(e)) begin
                    miscompares++;
                    $display("FAIL sb_result: got %0d want %0d", result, e);
                end
            end
        end
        rv_d <= result_valid;
    end

    task automatic do_reset();
        init_n = 1'b0; start = 1'b0; abort = 1'b0; s_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 init_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // One iteration from its first CLEAR cycle; optionally abort or reset at cycle stop_c.
    task automatic drive_iter(input int pat, input int it, input int stop_c,
                              input bit stop_rst, output int esum);
        bit xb[RUNL];
        bit sb[RUNL];
        int bad_init = 0, bad_rc = 0, bad_busy = 0, bad_rv = 0;
        esum = 0;
        for (int k = 0; k < RUNL; k++) begin
            case (pat)
                0: begin xb[k] = 1'b1; sb[k] = 1'b0; end
                1: begin xb[k] = 1'b1; sb[k] = ((k % 2) == 1); end
                2: begin xb[k] = 1'b1; sb[k] = ((it % 2) == 0); end
                default: begin xb[k] = 1'($urandom_range(0, 1)); sb[k] = 1'($urandom_range(0, 1)); end
            endcase
            if (k >= W && xb[k]) esum += sb[k] ? -1 : 1;
        end
        if (stop_c < 0) exp_q.push_back(esum);
        for (int c = 0; c < PERIOD; c++) begin
            if (c >= CLR && c < CLR + RUNL) begin
                x_out = xb[c-CLR]; sign_x = sb[c-CLR];
                if (Rc !== 2'(c - CLR)) bad_rc++;
            end else begin
                x_out = 1'($urandom_range(0, 1)); sign_x = 1'($urandom_range(0, 1));
            end
            if (istra_init !== (c < CLR)) bad_init++;
            if (busy !== 1'b1) bad_busy++;
            if (result_valid !== (c == PERIOD - 1)) bad_rv++;
            if (c == stop_c) begin
                if (stop_rst) init_n = 1'b0; else abort = 1'b1;
            end
            @(posedge clk); #1;
            if (c == stop_c) break;
        end
        vectors += 4;
        if (bad_init != 0) begin miscompares++; $display("FAIL istra_init_window: %0d bad cycles want 0", bad_init); end
        if (bad_rc != 0)   begin miscompares++; $display("FAIL rc_sequence: %0d bad cycles want 0", bad_rc); end
        if (bad_busy != 0) begin miscompares++; $display("FAIL busy_iter: %0d bad cycles want 0", bad_busy); end
        if (bad_rv != 0)   begin miscompares++; $display("FAIL result_valid_timing: %0d bad cycles want 0", bad_rv); end
    endtask

    // Full solve from the first CLEAR cycle, with an independent stopping model.
    task automatic run_solve(input int pat, input string name);
        int r, prev_r = 0, n_it = 0, d;
        bit conv = 1'b0;
        for (int it = 1; it <= MAXI; it++) begin
            drive_iter(pat, it, -1, 1'b0, r);
            n_it = it;
            d = r - prev_r;
            if (d < 0) d = -d;
            if (it >= 2 && d <= TOL) begin conv = 1'b1; break; end
            prev_r = r;
        end
        vectors += 4;
        if (done !== 1'b1) begin miscompares++; $display("FAIL %s_done: got %b want 1", name, done); end
        if (converged !== conv) begin miscompares++; $display("FAIL %s_converged: got %b want %b", name, converged, conv); end
        if (iter_count !== IT_W'(n_it)) begin miscompares++; $display("FAIL %s_iter: got %0d want %0d", name, iter_count, n_it); end
        if (result !== ACC_W'(r)) begin miscompares++; $display("FAIL %s_result: got %0d want %0d", name, result, r); end
        @(posedge clk); #1;
        vectors++;
        if ({done, busy, converged} !== {2'b00, conv}) begin
            miscompares++;
            $display("FAIL %s_after_done: done/busy/conv got %b want %b", name, {done, busy, converged}, {2'b00, conv});
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 2;
        if ({istra_init, Rc, busy, result_valid, result, iter_count, done, converged} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {istra_init, Rc, busy, result_valid, result, iter_count, done, converged});
        end
        if ({s_init, s_rc, s_busy, s_rv, s_result, s_iter, s_done, s_conv} !== '0) begin
            miscompares++;
            $display("FAIL reset_small_outputs: got %h want 0", {s_init, s_rc, s_busy, s_rv, s_result, s_iter, s_done, s_conv});
        end
    endtask

    task automatic test_reset_mid_run();
        int r;
        do_reset();
        do_start();
        drive_iter(0, 1, CLR + 100, 1'b1, r);
        init_n = 1'b1;
        vectors++;
        if ({istra_init, Rc, busy, result_valid, result, iter_count, done, converged} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: got %h want 0", {istra_init, Rc, busy, result_valid, result, iter_count, done, converged});
        end
        do_start();
        run_solve(0, "after_reset");
    endtask

    task automatic test_abort();
        int r;
        do_reset();
        do_start();
        drive_iter(2, 1, -1, 1'b0, r);
        drive_iter(2, 2, -1, 1'b0, r);
        drive_iter(2, 3, CLR + 50, 1'b0, r);
        abort = 1'b0;
        vectors += 3;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (iter_count !== IT_W'(2)) begin miscompares++; $display("FAIL abort_iter: got %0d want 2", iter_count); end
        if (result !== ACC_W'(-S)) begin miscompares++; $display("FAIL abort_result: got %0d want %0d", result, -S); end
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (done !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) seen++;
                @(posedge clk); #1;
            end
            vectors++;
            if (seen != 0) begin miscompares++; $display("FAIL abort_quiet: %0d active cycles want 0", seen); end
        end
    endtask

    task automatic test_hold_start();
        do_reset();
        start = 1'b1;
        @(posedge clk); #1;
        run_solve(0, "hold_start");
        @(posedge clk); #1;
        vectors++;
        if ({busy, istra_init, converged, iter_count} !== {3'b110, IT_W'(0)}) begin
            miscompares++;
            $display("FAIL hold_restart: busy/init/conv/iter got %b want %b", {busy, istra_init, converged, iter_count}, {3'b110, IT_W'(0)});
        end
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_abort_clear: busy got %b want 0", busy); end
    endtask

    task automatic test_start_abort();
        do_reset();
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL start_abort_busy: got %b want 1", busy); end
        run_solve(0, "start_abort");
    endtask

    task automatic test_small_window();
        do_reset();
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_x = 1'b1; s_sign = 1'b0;
        for (int c = 0; c <= 2 * SP; c++) begin
            if (c == SP - 1) begin
                vectors++;
                if (s_rv !== 1'b1) begin miscompares++; $display("FAIL small_rv: got %b want 1", s_rv); end
            end
            if (c == SP) begin
                vectors++;
                if (s_result !== 4'sd4) begin miscompares++; $display("FAIL small_result: got %0d want 4", s_result); end
            end
            if (c == 2 * SP) begin
                vectors++;
                if ({s_done, s_conv, s_iter} !== 4'b1110) begin
                    miscompares++;
                    $display("FAIL small_done: done/conv/iter got %b want 1110", {s_done, s_conv, s_iter});
                end
            end
            @(posedge clk); #1;
        end
        s_x = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        do_reset(); do_start(); run_solve(0, "positive");
        do_reset(); do_start(); run_solve(1, "balanced");
        do_reset(); do_start(); run_solve(2, "nonconv");
        do_reset(); do_start(); run_solve(3, "random");
        test_abort();
        test_hold_start();
        test_start_abort();
        test_small_window();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover: %0d pending want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
